// File: rtl/twofish_round_seq.sv
// Iterative Twofish round engine: one Feistel round per clock using an external
// combinational F-function, with a valid/ready handshake on both block ports.
module twofish_round_seq #(
  parameter int unsigned NUM_ROUNDS = 16,
  localparam int unsigned WORD_W = 32,
  localparam int unsigned CNT_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] in_r0,
  input  logic [WORD_W-1:0] in_r1,
  input  logic [WORD_W-1:0] in_r2,
  input  logic [WORD_W-1:0] in_r3,
  output logic [WORD_W-1:0] f_r0,
  output logic [WORD_W-1:0] f_r1,
  output logic [CNT_W-1:0]  f_round,
  input  logic [WORD_W-1:0] f_f0,
  input  logic [WORD_W-1:0] f_f1,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WORD_W-1:0] out_y0,
  output logic [WORD_W-1:0] out_y1,
  output logic [WORD_W-1:0] out_y2,
  output logic [WORD_W-1:0] out_y3
);

  localparam logic [CNT_W-1:0] LAST_ROUND = CNT_W'(NUM_ROUNDS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [WORD_W-1:0] r0, r1, r2, r3;
  logic [CNT_W-1:0]  cnt;
  logic              load_in;
  logic              do_round;
  logic              last_round;
  logic [WORD_W-1:0] t0, t1, c2, c3;

  // Round output transform: XOR then rotate right 1 / rotate left 1 then XOR
  always_comb begin
    t0 = f_f0 ^ r2;
    c2 = {t0[0], t0[WORD_W-1:1]};
    t1 = {r3[WORD_W-2:0], r3[WORD_W-1]};
    c3 = t1 ^ f_f1;
  end

  assign last_round = (cnt == LAST_ROUND);

  always_comb begin
    state_nxt = state;
    load_in   = 1'b0;
    do_round  = 1'b0;
    case (state)
      IDLE: begin
        if (in_valid) begin
          load_in   = 1'b1;
          state_nxt = ROUND;
        end
      end
      ROUND: begin
        do_round = 1'b1;
        if (last_round) state_nxt = DONE;
      end
      DONE: begin
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Handshake flags are registered alongside the state they decode
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      state     <= state_nxt;
      in_ready  <= (state_nxt == IDLE);
      out_valid <= (state_nxt == DONE);
    end
  end

  // Counter wraps to zero on the last round so it never exceeds NUM_ROUNDS-1
  always_ff @(posedge clk) begin
    if (rst) begin
      r0  <= '0;
      r1  <= '0;
      r2  <= '0;
      r3  <= '0;
      cnt <= '0;
    end else if (load_in) begin
      r0  <= in_r0;
      r1  <= in_r1;
      r2  <= in_r2;
      r3  <= in_r3;
      cnt <= '0;
    end else if (do_round) begin
      r0  <= c2;
      r1  <= c3;
      r2  <= r0;
      r3  <= r1;
      cnt <= last_round ? '0 : cnt + CNT_W'(1);
    end
  end

  assign f_r0    = r0;
  assign f_r1    = r1;
  assign f_round = cnt;

  // Final swap undone on the way out; zero unless a block is being presented
  assign out_y0 = (state == DONE) ? r2 : '0;
  assign out_y1 = (state == DONE) ? r3 : '0;
  assign out_y2 = (state == DONE) ? r0 : '0;
  assign out_y3 = (state == DONE) ? r1 : '0;

endmodule

// File: tb/tb_twofish_round_seq.sv
// Bench for twofish_round_seq: a 1-round and a 16-round instance, with a
// scoreboard of expected output blocks filled at accept time.
module tb_twofish_round_seq;

  typedef logic [3:0][31:0] blk_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        in_valid1, in_ready1, out_valid1, out_ready1;
  blk_t        in1;
  logic [31:0] f1_f0, f1_f1, fr0_1, fr1_1;
  logic [3:0]  fround_1;
  logic [31:0] y1_0, y1_1, y1_2, y1_3;

  logic        in_valid16, in_ready16, out_valid16, out_ready16;
  blk_t        in16;
  logic [31:0] f16_f0, f16_f1, fr0_16, fr1_16;
  logic [3:0]  fround_16;
  logic [31:0] y16_0, y16_1, y16_2, y16_3;
  bit          f16_mode;

  int   tests = 0;
  int   fails = 0;
  blk_t sb1[$];
  blk_t sb16[$];

  twofish_round_seq #(.NUM_ROUNDS(1)) u_dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1),
    .in_r0(in1[0]), .in_r1(in1[1]), .in_r2(in1[2]), .in_r3(in1[3]),
    .f_r0(fr0_1), .f_r1(fr1_1), .f_round(fround_1), .f_f0(f1_f0), .f_f1(f1_f1),
    .out_valid(out_valid1), .out_ready(out_ready1),
    .out_y0(y1_0), .out_y1(y1_1), .out_y2(y1_2), .out_y3(y1_3)
  );

  twofish_round_seq #(.NUM_ROUNDS(16)) u_dut16 (
    .clk(clk), .rst(rst), .in_valid(in_valid16), .in_ready(in_ready16),
    .in_r0(in16[0]), .in_r1(in16[1]), .in_r2(in16[2]), .in_r3(in16[3]),
    .f_r0(fr0_16), .f_r1(fr1_16), .f_round(fround_16), .f_f0(f16_f0), .f_f1(f16_f1),
    .out_valid(out_valid16), .out_ready(out_ready16),
    .out_y0(y16_0), .out_y1(y16_1), .out_y2(y16_2), .out_y3(y16_3)
  );

  function automatic logic [31:0] rol(input logic [31:0] x, input int s);
    return (x << s) | (x >> (32 - s));
  endfunction

  function automatic logic [31:0] fstub0(input bit mode, input logic [31:0] a,
                                         input logic [31:0] b, input logic [3:0] rnd);
    if (!mode) return 32'd0;
    return a ^ rol(b, 8) ^ (32'h9E37_79B9 * {28'd0, rnd});
  endfunction

  function automatic logic [31:0] fstub1(input bit mode, input logic [31:0] a,
                                         input logic [31:0] b, input logic [3:0] rnd);
    if (!mode) return 32'd0;
    return rol(a, 3) ^ rol(b, 17) ^ 32'hA5A5_0000 ^ {28'd0, rnd};
  endfunction

  // Combinational F-function stub for the 16-round instance
  always_comb begin
    f16_f0 = fstub0(f16_mode, fr0_16, fr1_16, fround_16);
    f16_f1 = fstub1(f16_mode, fr0_16, fr1_16, fround_16);
  end

  function automatic blk_t model(input blk_t x, input int n, input bit mode);
    logic [31:0] r0, r1, r2, r3, f0, f1, t0, c2, c3;
    blk_t y;
    r0 = x[0]; r1 = x[1]; r2 = x[2]; r3 = x[3];
    for (int i = 0; i < n; i++) begin
      f0 = fstub0(mode, r0, r1, 4'(i));
      f1 = fstub1(mode, r0, r1, 4'(i));
      t0 = f0 ^ r2;
      c2 = (t0 >> 1) | (t0 << 31);
      c3 = rol(r3, 1) ^ f1;
      r2 = r0; r3 = r1; r0 = c2; r1 = c3;
    end
    y[0] = r2; y[1] = r3; y[2] = r0; y[3] = r1;
    return y;
  endfunction

  function automatic blk_t rand_blk();
    blk_t b;
    for (int i = 0; i < 4; i++) b[i] = $urandom;
    return b;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cmp1(input string tag);
    blk_t e;
    chk({tag, " sb_depth"}, 32'(sb1.size()), 32'd1);
    if (sb1.size() > 0) begin
      e = sb1.pop_front();
      chk({tag, " y0"}, y1_0, e[0]);
      chk({tag, " y1"}, y1_1, e[1]);
      chk({tag, " y2"}, y1_2, e[2]);
      chk({tag, " y3"}, y1_3, e[3]);
    end
  endtask

  task automatic cmp16(input string tag);
    blk_t e;
    chk({tag, " sb_depth"}, 32'(sb16.size()), 32'd1);
    if (sb16.size() > 0) begin
      e = sb16.pop_front();
      chk({tag, " y0"}, y16_0, e[0]);
      chk({tag, " y1"}, y16_1, e[1]);
      chk({tag, " y2"}, y16_2, e[2]);
      chk({tag, " y3"}, y16_3, e[3]);
    end
  endtask

  task automatic wait_out16(input string tag, input int maxc, output int cyc);
    cyc = 0;
    while (!out_valid16 && cyc < maxc) begin
      step();
      cyc++;
    end
    chk({tag, " out_valid"}, 32'(out_valid16), 32'd1);
  endtask

  task automatic run1(input string tag, input blk_t b, input logic [31:0] f0,
                      input logic [31:0] f1, input blk_t exp);
    in1 = b; f1_f0 = f0; f1_f1 = f1;
    in_valid1 = 1'b1;
    sb1.push_back(exp);
    step();
    in_valid1 = 1'b0;
    chk({tag, " c1 out_valid"}, 32'(out_valid1), 32'd0);
    chk({tag, " c1 in_ready"}, 32'(in_ready1), 32'd0);
    step();
    chk({tag, " c2 out_valid"}, 32'(out_valid1), 32'd1);
    cmp1(tag);
    out_ready1 = 1'b1;
    step();
    out_ready1 = 1'b0;
    chk({tag, " post out_valid"}, 32'(out_valid1), 32'd0);
    chk({tag, " post in_ready"}, 32'(in_ready1), 32'd1);
  endtask

  task automatic start16(input blk_t b, input bit push);
    in16 = b;
    in_valid16 = 1'b1;
    if (push) sb16.push_back(model(b, 16, f16_mode));
    step();
    in_valid16 = 1'b0;
  endtask

  initial begin
    blk_t b, e;
    int   c, last_acc, nacc;

    rst = 1'b1;
    in_valid1 = 1'b0; out_ready1 = 1'b0; in1 = '0; f1_f0 = '0; f1_f1 = '0;
    in_valid16 = 1'b0; out_ready16 = 1'b0; in16 = '0; f16_mode = 1'b0;
    step();
    step();
    chk("rst in_ready1", 32'(in_ready1), 32'd1);
    chk("rst out_valid1", 32'(out_valid1), 32'd0);
    chk("rst y1_0", y1_0, 32'd0);
    chk("rst y1_3", y1_3, 32'd0);
    chk("rst f_r0_1", fr0_1, 32'd0);
    chk("rst f_r1_1", fr1_1, 32'd0);
    chk("rst f_round_1", 32'(fround_1), 32'd0);
    chk("rst in_ready16", 32'(in_ready16), 32'd1);
    chk("rst out_valid16", 32'(out_valid16), 32'd0);
    chk("rst f_r0_16", fr0_16, 32'd0);
    chk("rst f_r1_16", fr1_16, 32'd0);
    chk("rst f_round_16", 32'(fround_16), 32'd0);
    rst = 1'b0;
    step();

    // Single-round vectors with known answers
    b = '0; e = '0;
    b[0] = 32'h0000_0001; b[1] = 32'h0000_0002; b[2] = 32'h0000_0004; b[3] = 32'h8000_0000;
    e[0] = 32'h0000_0001; e[1] = 32'h0000_0002; e[2] = 32'h0000_0002; e[3] = 32'h0000_0001;
    run1("n1_vec1", b, 32'h0, 32'h0, e);
    b = '0; e = '0;
    e[2] = 32'hFFFF_FFFF; e[3] = 32'h0000_0001;
    run1("n1_vec2", b, 32'hFFFF_FFFF, 32'h0000_0001, e);

    // Sixteen rounds on a zero block with a zero F-function
    f16_mode = 1'b0;
    sb16.push_back(blk_t'(0));
    start16(blk_t'(0), 1'b0);
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("zero f_round r%0d", i), 32'(fround_16), 32'(i));
      chk($sformatf("zero out_valid r%0d", i), 32'(out_valid16), 32'd0);
      step();
    end
    chk("zero c17 out_valid", 32'(out_valid16), 32'd1);
    cmp16("zero");
    out_ready16 = 1'b1;
    step();
    out_ready16 = 1'b0;
    chk("zero post in_ready", 32'(in_ready16), 32'd1);

    // Back-pressure: outputs held for five cycles in DONE
    f16_mode = 1'b1;
    start16(rand_blk(), 1'b1);
    wait_out16("hold", 40, c);
    chk("hold latency", 32'(c), 32'd16);
    e = (sb16.size() > 0) ? sb16[0] : '0;
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("hold out_valid k%0d", k), 32'(out_valid16), 32'd1);
      chk($sformatf("hold in_ready k%0d", k), 32'(in_ready16), 32'd0);
      chk($sformatf("hold y0 k%0d", k), y16_0, e[0]);
      chk($sformatf("hold y3 k%0d", k), y16_3, e[3]);
      step();
    end
    out_ready16 = 1'b1;
    cmp16("hold");
    step();
    out_ready16 = 1'b0;
    chk("hold post in_ready", 32'(in_ready16), 32'd1);
    chk("hold post out_valid", 32'(out_valid16), 32'd0);

    // Reset in the middle of round 7 discards the block
    start16(rand_blk(), 1'b0);
    for (int i = 0; i < 7; i++) step();
    chk("mid f_round", 32'(fround_16), 32'd7);
    rst = 1'b1;
    step();
    chk("mid_rst in_ready", 32'(in_ready16), 32'd1);
    chk("mid_rst out_valid", 32'(out_valid16), 32'd0);
    chk("mid_rst y0", y16_0, 32'd0);
    rst = 1'b0;
    step();
    start16(rand_blk(), 1'b1);
    wait_out16("after_rst", 40, c);
    chk("after_rst latency", 32'(c), 32'd16);
    out_ready16 = 1'b1;
    cmp16("after_rst");
    step();
    out_ready16 = 1'b0;

    // in_valid held high: accepts only from IDLE, spaced NUM_ROUNDS+2 apart
    in_valid16 = 1'b1;
    out_ready16 = 1'b1;
    in16 = rand_blk();
    last_acc = 0;
    nacc = 0;
    for (int cyc = 0; cyc < 80; cyc++) begin
      if (in_ready16) begin
        if (nacc > 0) chk("stream spacing", 32'(cyc - last_acc), 32'd18);
        sb16.push_back(model(in16, 16, f16_mode));
        last_acc = cyc;
        nacc++;
      end
      if (out_valid16) cmp16("stream");
      step();
      in16 = rand_blk();
    end
    in_valid16 = 1'b0;
    chk("stream accepts", 32'(nacc), 32'd5);
    wait_out16("drain", 40, c);
    if (out_valid16) cmp16("drain");
    step();
    out_ready16 = 1'b0;
    chk("drain sb empty", 32'(sb16.size()), 32'd0);
    chk("drain in_ready", 32'(in_ready16), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
